// File: rtl/lce_req_admission_ctrl_pkg.sv
// Shared defaults and width helper for the LCE request admission controller.
package lce_req_admission_ctrl_pkg;

  localparam int default_credits_lp       = 8;
  localparam int default_timeout_max_lp   = 4;

  // Bits needed to hold every value in [0, max_val].
  function automatic int count_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; clear and up together restart the count at one.
module bsg_counter_clear_up #(
  parameter int max_val_p    = 1,
  parameter int init_val_p   = 0,
  parameter int ptr_width_lp = $clog2(max_val_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clear_i,
  input  logic                    up_i,
  output logic [ptr_width_lp-1:0] count_o
);

  typedef logic [ptr_width_lp-1:0] count_t;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk_i) begin
    if (reset_i)      count_o <= count_t'(init_val_p);
    else if (clear_i) count_o <= count_t'(up_i);
    else if (up_i)    count_o <= count_o + count_t'(1);
  end

endmodule

// File: rtl/lce_req_admission_ctrl.sv
// Cache-facing admission control: outstanding LCE credits plus a memory-port
// starvation timeout, folded with engine readiness into one busy signal.
module lce_req_admission_ctrl
  import lce_req_admission_ctrl_pkg::*;
#(
  parameter int credits_p           = default_credits_lp,
  parameter int timeout_max_limit_p = default_timeout_max_lp
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  cache_req_v_i,
  output logic                                  cache_req_v_o,
  input  logic                                  req_ready_i,
  input  logic                                  cmd_ready_i,
  input  logic                                  lce_req_send_i,
  input  logic                                  cache_req_complete_i,
  input  logic                                  uc_store_complete_i,
  input  logic                                  data_mem_pkt_v_i,
  input  logic                                  data_mem_pkt_yumi_i,
  input  logic                                  tag_mem_pkt_v_i,
  input  logic                                  tag_mem_pkt_yumi_i,
  input  logic                                  stat_mem_pkt_v_i,
  input  logic                                  stat_mem_pkt_yumi_i,
  output logic                                  cache_req_busy_o,
  output logic                                  credits_full_o,
  output logic                                  credits_empty_o,
  output logic                                  timeout_o,
  output logic [count_width(credits_p)-1:0]     credit_count_o
);

  localparam int credit_width_lp  = count_width(credits_p);
  localparam int timeout_width_lp = count_width(timeout_max_limit_p);

  typedef logic [credit_width_lp-1:0] credit_t;
  typedef logic [credit_width_lp:0]   credit_ext_t;
  typedef logic [timeout_width_lp-1:0] timeout_t;

  localparam credit_ext_t credits_max_lp = credit_ext_t'(credits_p);

  // Timeout: counts consecutive cycles in which any LCE memory port is held off.
  logic     blocked;
  timeout_t timeout_count;

  assign blocked = (data_mem_pkt_v_i & ~data_mem_pkt_yumi_i)
                 | (tag_mem_pkt_v_i  & ~tag_mem_pkt_yumi_i)
                 | (stat_mem_pkt_v_i & ~stat_mem_pkt_yumi_i);

  bsg_counter_clear_up #(
    .max_val_p    (timeout_max_limit_p),
    .init_val_p   (0),
    .ptr_width_lp (timeout_width_lp)
  ) timeout_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (~blocked),
    .up_i    (blocked & ~timeout_o),
    .count_o (timeout_count)
  );

  assign timeout_o = (timeout_count == timeout_t'(timeout_max_limit_p));

  // Credits: one extra bit of headroom so send-before-return never wraps.
  credit_t     credit_count_r;
  credit_t     credit_next;
  credit_ext_t credit_inc;
  credit_ext_t credit_dec;
  credit_ext_t credit_diff;
  logic        credit_underflow;
  logic        credit_overflow;

  assign credit_inc       = {1'b0, credit_count_r} + credit_ext_t'(lce_req_send_i);
  assign credit_dec       = credit_ext_t'(cache_req_complete_i) + credit_ext_t'(uc_store_complete_i);
  assign credit_diff      = credit_inc - credit_dec;
  assign credit_underflow = (credit_dec > credit_inc);
  assign credit_overflow  = ~credit_underflow & (credit_diff > credits_max_lp);

  // NOTE: credit_next gets a value on every path, so no latch is inferred.
  always_comb begin
    credit_next = credit_t'(credit_diff);
    if (credit_underflow)     credit_next = '0;
    else if (credit_overflow) credit_next = credit_t'(credits_p);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) credit_count_r <= '0;
    else         credit_count_r <= credit_next;
  end

  assign credit_count_o  = credit_count_r;
  assign credits_full_o  = (credit_count_r == credit_t'(credits_p));
  assign credits_empty_o = (credit_count_r == '0);

  assign cache_req_busy_o = credits_full_o | timeout_o | ~cmd_ready_i | ~req_ready_i;
  assign cache_req_v_o    = cache_req_v_i & ~cache_req_busy_o;

  credit_bounds_a: assert property (@(posedge clk_i) disable iff (reset_i)
                                    !(credit_overflow || credit_underflow))
    else $error("lce_req_admission_ctrl: credit counter overflow/underflow");

endmodule

// File: tb/tb_lce_req_admission_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// run-length / clamped-sum reference model.
module tb_lce_req_admission_ctrl;

  localparam int credits_lp = 8;
  localparam int timeout_lp = 4;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       cache_req_v_i, cache_req_v_o;
  logic       req_ready_i, cmd_ready_i;
  logic       lce_req_send_i, cache_req_complete_i, uc_store_complete_i;
  logic       data_mem_pkt_v_i, data_mem_pkt_yumi_i;
  logic       tag_mem_pkt_v_i, tag_mem_pkt_yumi_i;
  logic       stat_mem_pkt_v_i, stat_mem_pkt_yumi_i;
  logic       cache_req_busy_o, credits_full_o, credits_empty_o, timeout_o;
  logic [3:0] credit_count_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: outstanding credits and length of the current blocked run.
  int m_credits;
  int m_run;

  lce_req_admission_ctrl #(
    .credits_p           (credits_lp),
    .timeout_max_limit_p (timeout_lp)
  ) dut (
    .clk_i                (clk_i),
    .reset_i              (reset_i),
    .cache_req_v_i        (cache_req_v_i),
    .cache_req_v_o        (cache_req_v_o),
    .req_ready_i          (req_ready_i),
    .cmd_ready_i          (cmd_ready_i),
    .lce_req_send_i       (lce_req_send_i),
    .cache_req_complete_i (cache_req_complete_i),
    .uc_store_complete_i  (uc_store_complete_i),
    .data_mem_pkt_v_i     (data_mem_pkt_v_i),
    .data_mem_pkt_yumi_i  (data_mem_pkt_yumi_i),
    .tag_mem_pkt_v_i      (tag_mem_pkt_v_i),
    .tag_mem_pkt_yumi_i   (tag_mem_pkt_yumi_i),
    .stat_mem_pkt_v_i     (stat_mem_pkt_v_i),
    .stat_mem_pkt_yumi_i  (stat_mem_pkt_yumi_i),
    .cache_req_busy_o     (cache_req_busy_o),
    .credits_full_o       (credits_full_o),
    .credits_empty_o      (credits_empty_o),
    .timeout_o            (timeout_o),
    .credit_count_o       (credit_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit model_blocked();
    return (data_mem_pkt_v_i && !data_mem_pkt_yumi_i) ||
           (tag_mem_pkt_v_i  && !tag_mem_pkt_yumi_i)  ||
           (stat_mem_pkt_v_i && !stat_mem_pkt_yumi_i);
  endfunction

  task automatic check_all();
    bit full, tmo, busy;
    full = (m_credits == credits_lp);
    tmo  = (m_run >= timeout_lp);
    busy = full || tmo || !cmd_ready_i || !req_ready_i;
    check("credit_count", 32'(credit_count_o), 32'(m_credits));
    check("credits_full", 32'(credits_full_o), 32'(full));
    check("credits_empty", 32'(credits_empty_o), 32'(m_credits == 0));
    check("timeout", 32'(timeout_o), 32'(tmo));
    check("busy", 32'(cache_req_busy_o), 32'(busy));
    check("req_v_o", 32'(cache_req_v_o), 32'(cache_req_v_i && !busy));
  endtask

  // Advance one clock, update the model with the inputs the DUT just sampled, then compare.
  task automatic tick();
    int next;
    @(posedge clk_i);
    if (reset_i) begin
      m_credits = 0;
      m_run     = 0;
    end else begin
      next = m_credits + int'(lce_req_send_i) - int'(cache_req_complete_i) - int'(uc_store_complete_i);
      m_credits = (next < 0) ? 0 : (next > credits_lp) ? credits_lp : next;
      m_run     = model_blocked() ? m_run + 1 : 0;
    end
    #1;
    check_all();
  endtask

  task automatic idle();
    cache_req_v_i        = 1'b1;
    req_ready_i          = 1'b1;
    cmd_ready_i          = 1'b1;
    lce_req_send_i       = 1'b0;
    cache_req_complete_i = 1'b0;
    uc_store_complete_i  = 1'b0;
    data_mem_pkt_v_i     = 1'b0;
    data_mem_pkt_yumi_i  = 1'b0;
    tag_mem_pkt_v_i      = 1'b0;
    tag_mem_pkt_yumi_i   = 1'b0;
    stat_mem_pkt_v_i     = 1'b0;
    stat_mem_pkt_yumi_i  = 1'b0;
  endtask

  initial begin
    int send, comp, uc;
    bit heavy;

    idle();
    reset_i   = 1'b1;
    m_credits = 0;
    m_run     = 0;
    tick();
    tick();
    reset_i = 1'b0;
    tick();
    check("rst_count", 32'(credit_count_o), 32'd0);
    check("rst_empty", 32'(credits_empty_o), 32'd1);
    check("rst_timeout", 32'(timeout_o), 32'd0);
    check("rst_busy", 32'(cache_req_busy_o), 32'd0);
    check("rst_req_v_o", 32'(cache_req_v_o), 32'd1);

    // Fill all credits.
    lce_req_send_i = 1'b1;
    repeat (8) tick();
    lce_req_send_i = 1'b0;
    #1;
    check("fill_count", 32'(credit_count_o), 32'd8);
    check("fill_full", 32'(credits_full_o), 32'd1);
    check("fill_busy", 32'(cache_req_busy_o), 32'd1);
    check("fill_req_v_o", 32'(cache_req_v_o), 32'd0);
    cache_req_complete_i = 1'b1;
    tick();
    cache_req_complete_i = 1'b0;
    check("ret1_count", 32'(credit_count_o), 32'd7);
    check("ret1_busy", 32'(cache_req_busy_o), 32'd0);

    // Drain to 3, then simultaneous send/return and double return.
    cache_req_complete_i = 1'b1;
    repeat (4) tick();
    lce_req_send_i = 1'b1;
    tick();
    check("send_ret_count", 32'(credit_count_o), 32'd3);
    lce_req_send_i      = 1'b0;
    uc_store_complete_i = 1'b1;
    tick();
    check("dbl_ret_count", 32'(credit_count_o), 32'd1);
    cache_req_complete_i = 1'b0;
    uc_store_complete_i  = 1'b0;

    // Tag port starved for six cycles.
    tag_mem_pkt_v_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("starve_timeout", 32'(timeout_o), 32'(i >= 3));
    end
    check("starve_busy", 32'(cache_req_busy_o), 32'd1);
    tag_mem_pkt_yumi_i = 1'b1;
    tick();
    check("unstarve_timeout", 32'(timeout_o), 32'd0);
    idle();

    // Two short blocked runs separated by one free cycle never time out.
    stat_mem_pkt_v_i = 1'b1;
    repeat (3) tick();
    stat_mem_pkt_yumi_i = 1'b1;
    tick();
    stat_mem_pkt_yumi_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("short_run_timeout", 32'(timeout_o), 32'd0);
    end
    idle();
    tick();

    // Engine readiness gates busy with zero latency.
    cmd_ready_i = 1'b0;
    #1;
    check("cmd_busy", 32'(cache_req_busy_o), 32'd1);
    check("cmd_req_v_o", 32'(cache_req_v_o), 32'd0);
    cmd_ready_i = 1'b1;
    req_ready_i = 1'b0;
    #1;
    check("req_busy", 32'(cache_req_busy_o), 32'd1);
    check("req_req_v_o", 32'(cache_req_v_o), 32'd0);
    req_ready_i = 1'b1;

    // Reset with credits outstanding discards them.
    lce_req_send_i = 1'b1;
    repeat (4) tick();
    lce_req_send_i = 1'b0;
    check("pre_rst_count", 32'(credit_count_o), 32'd5);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("mid_rst_count", 32'(credit_count_o), 32'd0);
    check("mid_rst_empty", 32'(credits_empty_o), 32'd1);

    // Randomized traffic; credit operations kept inside the legal range.
    for (int i = 0; i < 600; i++) begin
      heavy = ((i / 25) % 2) == 1;
      send  = ($urandom_range(9, 0) < 6) ? 1 : 0;
      comp  = $urandom_range(1, 0);
      uc    = ($urandom_range(3, 0) == 0) ? 1 : 0;
      if (m_credits + send - comp - uc > credits_lp) send = 0;
      if (m_credits + send - comp - uc < 0) comp = 0;
      if (m_credits + send - comp - uc < 0) uc = 0;
      lce_req_send_i       = send[0];
      cache_req_complete_i = comp[0];
      uc_store_complete_i  = uc[0];
      cache_req_v_i        = 1'($urandom_range(1, 0));
      cmd_ready_i          = ($urandom_range(9, 0) != 0);
      req_ready_i          = ($urandom_range(9, 0) != 0);
      data_mem_pkt_v_i     = heavy ? ($urandom_range(1, 0) == 0) : ($urandom_range(3, 0) == 0);
      tag_mem_pkt_v_i      = heavy ? ($urandom_range(1, 0) == 0) : ($urandom_range(3, 0) == 0);
      stat_mem_pkt_v_i     = heavy ? ($urandom_range(1, 0) == 0) : ($urandom_range(3, 0) == 0);
      data_mem_pkt_yumi_i  = heavy ? ($urandom_range(3, 0) == 0) : ($urandom_range(1, 0) == 0);
      tag_mem_pkt_yumi_i   = heavy ? ($urandom_range(3, 0) == 0) : ($urandom_range(1, 0) == 0);
      stat_mem_pkt_yumi_i  = heavy ? ($urandom_range(3, 0) == 0) : ($urandom_range(1, 0) == 0);
      reset_i              = ($urandom_range(99, 0) == 0);
      #1;
      check_all();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lce_req_admission_ctrl.md
Name: lce_req_admission_ctrl

Overview:
- Admission controller that sits between a cache and its Local Cache/Coherence Engine (LCE) request/command engines.
- Tracks outstanding coherence-request credits.
- Detects when the LCE has been starved of data/tag/stat memory port access for too long (timeout).
- Combines these with engine-ready signals into one cache-facing busy signal, and gates the cache request valid with it.

Parameters:
- credits_p, 8: maximum outstanding LCE requests; must be ≥1.
- timeout_max_limit_p, 4: consecutive blocked cycles before timeout asserts; must be ≥1.
- Derived credit_width = clog2(credits_p+1).
- Derived timeout_width = clog2(timeout_max_limit_p+1).

Ports:
- clk_i  in  1  clock, all state rises on posedge.
- reset_i  in  1  synchronous, active-high reset.
- cache_req_v_i  in  1  cache request valid.
- cache_req_v_o  out  1  gated valid to request engine = cache_req_v_i & ~cache_req_busy_o.
- req_ready_i  in  1  request engine idle/ready.
- cmd_ready_i  in  1  command engine initialised and ready.
- lce_req_send_i  in  1  one LCE request leaves this cycle (consumes a credit).
- cache_req_complete_i  in  1  one request completes (returns a credit).
- uc_store_complete_i  in  1  one uncached store completes (returns a credit).
- data_mem_pkt_v_i / data_mem_pkt_yumi_i  in  1/1  LCE data-mem port handshake.
- tag_mem_pkt_v_i / tag_mem_pkt_yumi_i  in  1/1  LCE tag-mem port handshake.
- stat_mem_pkt_v_i / stat_mem_pkt_yumi_i  in  1/1  LCE stat-mem port handshake.
- cache_req_busy_o  out  1  cache must not issue a request.
- credits_full_o  out  1  credit count == credits_p.
- credits_empty_o  out  1  credit count == 0.
- timeout_o  out  1  timeout count == timeout_max_limit_p.
- credit_count_o  out  credit_width  outstanding-credit count (debug/verification).

Behaviour:
- Blocked condition: blocked = OR over data/tag/stat of (pkt_v & ~pkt_yumi).
- Timeout counter:
  - Clears to 0 in any cycle where blocked=0.
  - Increments by 1 in any cycle where blocked=1.
  - Saturates at timeout_max_limit_p and never wraps.
  - timeout_o is combinational from the registered count, so it first asserts after timeout_max_limit_p consecutive blocked cycles.
  - timeout_o stays high while blocked persists and drops the cycle after blocked falls.
- Credit counter:
  - next = count + lce_req_send_i − cache_req_complete_i − uc_store_complete_i.
  - Send plus one return in the same cycle leaves the count unchanged.
  - Two returns in one cycle decrement by 2.
  - Result is clamped to the range [0, credits_p].
  - Overflow or underflow attempts are simulation errors (assertion, $error); RTL clamps.
- credits_full_o and credits_empty_o are combinational from the registered count.
- cache_req_busy_o = credits_full_o | timeout_o | ~cmd_ready_i | ~req_ready_i. It is purely combinational, with zero latency from the ready inputs.
- cache_req_v_o never asserts while busy; this guarantees no request-engine yumi while busy.
- Reset values:
  - Both counters 0.
  - credits_full_o=0, credits_empty_o=1, timeout_o=0.
  - busy_o and cache_req_v_o follow inputs combinationally.
- Reset mid-operation clears both counters the next edge; in-flight credits are discarded.
- Timing: no combinational path from the credit-return inputs to the outputs; only count registers feed the status flags.

Decomposition:
- No new package typedefs; widths are computed locally from parameters.
- Timeout counter: instantiate the existing bsg_counter_clear_up with max_val_p=timeout_max_limit_p, init_val_p=0.
  - Saturation needs either a wrapper condition (up_i = blocked & ~timeout) or a local counter.
  - Use up_i = blocked & ~timeout_o and clear_i = ~blocked.
- Credit counter is a small local up/down saturating register; no separate sub-module.

Test Plan:
- Reset with req_ready_i=cmd_ready_i=1 and all pkt_v=0: credit_count_o=0, credits_empty_o=1, timeout_o=0, busy_o=0; cache_req_v_i=1 gives cache_req_v_o=1.
- Pulse lce_req_send_i for 8 cycles (credits_p=8): count reaches 8, credits_full_o=1, busy_o=1, cache_req_v_o=0 with cache_req_v_i=1. One cache_req_complete_i pulse: count 7, busy_o=0 next cycle.
- Same-cycle send and complete at count 3: count stays 3. complete and uc_store_complete together at 3: count 1.
- tag_mem_pkt_v_i=1, yumi=0 for 6 cycles: timeout_o rises after the 4th blocked edge, stays 1, busy_o=1. Assert yumi: timeout_o=0 the following cycle.
- Blocked 3 cycles, one unblocked cycle, blocked 3 more: timeout_o never asserts (counter cleared).
- cmd_ready_i=0 or req_ready_i=0 with all else idle: busy_o=1, cache_req_v_o=0. Assert reset with count=5: count=0, empty=1 next cycle.
